// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and stall-cause encodings for the hazard controller
package hazard_pkg;

   localparam int SB_ADDR_W = 8;
   localparam int SB_RDY_W  = 4;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'd0,
      CAUSE_LOADUSE = 2'd1,
      CAUSE_EARLY   = 2'd2,
      CAUSE_MDU     = 2'd3
   } stall_cause_e;

   typedef struct packed {
      logic                 valid;
      logic [SB_ADDR_W-1:0] addr;
      logic [SB_RDY_W-1:0]  ready;
   } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight writer shift register with per-stage operand compare
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int  NREG       = 32,
   parameter int  SB_DEPTH   = 3,
   parameter int  ALU_READY  = 1,
   parameter int  LOAD_READY = 2,
   localparam int AW         = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                push_valid,
   input  logic [AW-1:0]       push_addr,
   input  logic                push_is_load,
   input  logic [AW-1:0]       rs,
   input  logic [AW-1:0]       rt,
   input  logic                rs_used,
   input  logic                rt_used,
   output logic [SB_DEPTH-1:0] rs_match,
   output logic [SB_DEPTH-1:0] rt_match,
   output logic [SB_DEPTH-1:0] rdy_gt,
   output logic [SB_DEPTH-1:0] rdy_ge
);

   sb_entry_t sb_q [SB_DEPTH];
   sb_entry_t entry1_d;

   always_comb begin
      entry1_d       = '0;
      entry1_d.valid = push_valid;
      entry1_d.addr  = SB_ADDR_W'(push_addr);
      entry1_d.ready = push_is_load ? SB_RDY_W'(LOAD_READY) : SB_RDY_W'(ALU_READY);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SB_DEPTH; i++) sb_q[i] <= '0;
      end else begin
         sb_q[0] <= entry1_d;
         for (int i = 1; i < SB_DEPTH; i++) sb_q[i] <= sb_q[i-1];
      end
   end

   // Array index s holds the instruction in pipeline stage s+1.
   for (genvar s = 0; s < SB_DEPTH; s++) begin : g_cmp
      assign rs_match[s] = rs_used && (rs != '0) && sb_q[s].valid && (sb_q[s].addr == SB_ADDR_W'(rs));
      assign rt_match[s] = rt_used && (rt != '0) && sb_q[s].valid && (sb_q[s].addr == SB_ADDR_W'(rt));
      assign rdy_gt[s]   = sb_q[s].ready >  SB_RDY_W'(s + 1);
      assign rdy_ge[s]   = sb_q[s].ready >= SB_RDY_W'(s + 1);
   end

endmodule

// File: rtl/hazard_ctrl_sb.sv
// rtl/hazard_ctrl_sb.sv - hazard priority, MDU busy counter, optional HAZARD_STATS_EN stall counters
module hazard_ctrl_sb
   import hazard_pkg::*;
#(
   parameter int  NREG       = 32,
   parameter int  SB_DEPTH   = 3,
   parameter int  ALU_READY  = 1,
   parameter int  LOAD_READY = 2,
   parameter int  MDU_LAT    = 8,
   localparam int AW         = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          id_valid,
   input  logic [AW-1:0] id_rs,
   input  logic [AW-1:0] id_rt,
   input  logic          id_rs_used,
   input  logic          id_rt_used,
   input  logic          id_early,
   input  logic          id_wr_en,
   input  logic [AW-1:0] id_wr_addr,
   input  logic          id_is_load,
   input  logic          id_mdu_issue,
   input  logic          id_hilo_rd,
   input  logic          id_redirect,
   output logic          pc_we,
   output logic          ifid_stall,
   output logic          ifid_flush,
   output logic          idex_flush,
   output logic          mdu_busy,
   output logic [1:0]    stall_cause
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]   stat_loaduse,
   output logic [31:0]   stat_early,
   output logic [31:0]   stat_mdu
`endif
);

   localparam int CW = $clog2(MDU_LAT + 1);

   logic [SB_DEPTH-1:0] rs_match, rt_match, rdy_gt, rdy_ge, any_match;
   logic [CW-1:0]       mdu_cnt_q, mdu_cnt_d;
   logic                hz_loaduse, hz_early, hz_mdu, stall, push_valid, busy;
   stall_cause_e        cause;

   hazard_scoreboard #(
      .NREG       (NREG),
      .SB_DEPTH   (SB_DEPTH),
      .ALU_READY  (ALU_READY),
      .LOAD_READY (LOAD_READY)
   ) u_sb (
      .clk          (clk),
      .rst_n        (rst_n),
      .push_valid   (push_valid),
      .push_addr    (id_wr_addr),
      .push_is_load (id_is_load),
      .rs           (id_rs),
      .rt           (id_rt),
      .rs_used      (id_rs_used),
      .rt_used      (id_rt_used),
      .rs_match     (rs_match),
      .rt_match     (rt_match),
      .rdy_gt       (rdy_gt),
      .rdy_ge       (rdy_ge)
   );

   assign any_match = rs_match | rt_match;
   assign busy      = (mdu_cnt_q != '0);

   // Gating the cause with rst_n releases any stall the instant reset asserts.
   always_comb begin
      hz_loaduse = id_valid && (|(any_match & rdy_gt));
      hz_early   = id_valid && id_early && (|(any_match & rdy_ge));
      hz_mdu     = id_valid && (id_mdu_issue || id_hilo_rd) && busy;
      cause      = CAUSE_NONE;
      if (!rst_n)          cause = CAUSE_NONE;
      else if (hz_loaduse) cause = CAUSE_LOADUSE;
      else if (hz_early)   cause = CAUSE_EARLY;
      else if (hz_mdu)     cause = CAUSE_MDU;
      stall = (cause != CAUSE_NONE);
   end

   assign push_valid  = id_valid && !stall && id_wr_en && (id_wr_addr != '0);
   assign pc_we       = !stall;
   assign ifid_stall  = stall;
   assign idex_flush  = stall;
   assign ifid_flush  = rst_n && id_redirect && !stall;
   assign mdu_busy    = rst_n && busy;
   assign stall_cause = cause;

   always_comb begin
      mdu_cnt_d = mdu_cnt_q;
      if (id_valid && id_mdu_issue && !stall) mdu_cnt_d = CW'(MDU_LAT);
      else if (busy)                          mdu_cnt_d = mdu_cnt_q - CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mdu_cnt_q <= '0;
      else        mdu_cnt_q <= mdu_cnt_d;
   end

`ifdef HAZARD_STATS_EN
   logic [31:0] st_lu_q, st_early_q, st_mdu_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_lu_q    <= '0;
         st_early_q <= '0;
         st_mdu_q   <= '0;
      end else begin
         if (cause == CAUSE_LOADUSE && st_lu_q    != '1) st_lu_q    <= st_lu_q + 32'd1;
         if (cause == CAUSE_EARLY   && st_early_q != '1) st_early_q <= st_early_q + 32'd1;
         if (cause == CAUSE_MDU     && st_mdu_q   != '1) st_mdu_q   <= st_mdu_q + 32'd1;
      end
   end

   assign stat_loaduse = st_lu_q;
   assign stat_early   = st_early_q;
   assign stat_mdu     = st_mdu_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// tb/tb_hazard_ctrl_sb.sv - directed self-checking bench for hazard_ctrl_sb
module tb_hazard_ctrl_sb;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       id_valid, id_rs_used, id_rt_used, id_early, id_wr_en, id_is_load;
   logic       id_mdu_issue, id_hilo_rd, id_redirect;
   logic [4:0] id_rs, id_rt, id_wr_addr;
   logic       pc_we, ifid_stall, ifid_flush, idex_flush, mdu_busy;
   logic [1:0] stall_cause;
   wire  [6:0] obs = {pc_we, ifid_stall, ifid_flush, idex_flush, mdu_busy, stall_cause};

   int tests = 0;
   int fails = 0;

   // obs layout: {pc_we, ifid_stall, ifid_flush, idex_flush, mdu_busy, cause[1:0]}
   localparam logic [6:0] O_RUN   = 7'b1000000;
   localparam logic [6:0] O_LU    = 7'b0101001;
   localparam logic [6:0] O_EARLY = 7'b0101010;
   localparam logic [6:0] O_MDU   = 7'b0101111;
   localparam logic [6:0] O_REDIR = 7'b1010000;

   always #5 clk = ~clk;

   hazard_ctrl_sb dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_valid     (id_valid),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_rs_used   (id_rs_used),
      .id_rt_used   (id_rt_used),
      .id_early     (id_early),
      .id_wr_en     (id_wr_en),
      .id_wr_addr   (id_wr_addr),
      .id_is_load   (id_is_load),
      .id_mdu_issue (id_mdu_issue),
      .id_hilo_rd   (id_hilo_rd),
      .id_redirect  (id_redirect),
      .pc_we        (pc_we),
      .ifid_stall   (ifid_stall),
      .ifid_flush   (ifid_flush),
      .idex_flush   (idex_flush),
      .mdu_busy     (mdu_busy),
      .stall_cause  (stall_cause)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0; id_early = 0;
      id_wr_en = 0; id_wr_addr = 0; id_is_load = 0; id_mdu_issue = 0; id_hilo_rd = 0; id_redirect = 0;
   endtask

   task automatic set_id(input logic [4:0] rs, input logic rsu, input logic [4:0] rt, input logic rtu,
                         input logic early, input logic wr, input logic [4:0] wa, input logic ld,
                         input logic mdu, input logic hilo, input logic redir);
      id_valid = 1; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu; id_early = early;
      id_wr_en = wr; id_wr_addr = wa; id_is_load = ld; id_mdu_issue = mdu; id_hilo_rd = hilo; id_redirect = redir;
   endtask

   task automatic drain();
      set_idle();
      repeat (4) tick();
   endtask

   task automatic test_reset();
      rst_n = 0;
      set_idle();
      tick();
      #4;
      tests++; if (obs !== O_RUN) begin fails++; $display("FAIL reset_idle got %b exp %b", obs, O_RUN); end
      set_id(5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, 1);
      #1;
      tests++; if (obs !== O_RUN) begin fails++; $display("FAIL reset_forced got %b exp %b", obs, O_RUN); end
      tick();
      rst_n = 1;
      set_idle();
      #4;
      tests++; if (obs !== O_RUN) begin fails++; $display("FAIL reset_release got %b exp %b", obs, O_RUN); end
      tick();
   endtask

   task automatic test_load_use();
      set_id(5'd29, 1, 5'd0, 0, 0, 1, 5'd2, 1, 0, 0, 0);        // lw $2,0($29)
      #4;
      tests++; if (obs !== O_RUN) begin fails++; $display("FAIL lu_lw_issue got %b exp %b", obs, O_RUN); end
      tick();
      set_id(5'd2, 1, 5'd4, 1, 0, 1, 5'd3, 0, 0, 0, 0);         // add $3,$2,$4
      #4;
      tests++; if (obs !== O_LU) begin fails++; $display("FAIL lu_stall got %b exp %b", obs, O_LU); end
      tick();
      #4;
      tests++; if (obs !== O_RUN) begin fails++; $display("FAIL lu_add_issue got %b exp %b", obs, O_RUN); end
      tick();
      drain();
   endtask

   task automatic test_early();
      int  n;
      logic done;
      set_id(5'd1, 1, 5'd1, 1, 0, 1, 5'd5, 0, 0, 0, 0);         // add $5
      #4; tick();
      set_id(5'd5, 1, 5'd6, 1, 1, 0, 5'd0, 0, 0, 0, 0);         // beq $5,$6
      #4;
      tests++; if (obs !== O_EARLY) begin fails++; $display("FAIL early_alu_stall got %b exp %b", obs, O_EARLY); end
      tick();
      #4;
      tests++; if (obs !== O_RUN) begin fails++; $display("FAIL early_alu_issue got %b exp %b", obs, O_RUN); end
      tick();
      drain();
      set_id(5'd29, 1, 5'd0, 0, 0, 1, 5'd5, 1, 0, 0, 0);        // lw $5
      #4; tick();
      set_id(5'd5, 1, 5'd6, 1, 1, 0, 5'd0, 0, 0, 0, 0);         // beq $5,$6
      n = 0; done = 0;
      for (int k = 0; k < 10 && !done; k++) begin
         #4;
         if (pc_we === 1'b0) begin n++; tick(); end else done = 1;
      end
      tests++; if (n != 2) begin fails++; $display("FAIL early_load_cycles got %0d exp 2", n); end
      tick();
      drain();
   endtask

   task automatic test_zero_reg();
      set_id(5'd1, 1, 5'd0, 0, 0, 1, 5'd0, 1, 0, 0, 0);         // lw $0
      #4; tick();
      set_id(5'd0, 1, 5'd0, 1, 1, 1, 5'd9, 0, 0, 0, 0);         // early consumer of $0
      #4;
      tests++; if (obs !== O_RUN) begin fails++; $display("FAIL zero_reg got %b exp %b", obs, O_RUN); end
      tick();
      drain();
   endtask

   task automatic mdu_pair(input string tag);
      int  n;
      logic done;
      set_id(5'd1, 1, 5'd2, 1, 0, 0, 5'd0, 0, 1, 0, 0);         // div $1,$2
      #4;
      tests++; if (obs !== O_RUN) begin fails++; $display("FAIL %s_div_issue got %b exp %b", tag, obs, O_RUN); end
      tick();
      set_id(5'd0, 0, 5'd0, 0, 0, 1, 5'd8, 0, 0, 1, 0);         // mflo $8
      n = 0; done = 0;
      for (int k = 0; k < 20 && !done; k++) begin
         #4;
         if (k == 0) begin
            tests++; if (obs !== O_MDU) begin fails++; $display("FAIL %s_mdu_stall got %b exp %b", tag, obs, O_MDU); end
         end
         if (pc_we === 1'b0) begin n++; tick(); end else done = 1;
      end
      tests++; if (n != 8) begin fails++; $display("FAIL %s_mdu_cycles got %0d exp 8", tag, n); end
      tests++; if (obs !== O_RUN) begin fails++; $display("FAIL %s_mflo_issue got %b exp %b", tag, obs, O_RUN); end
      tick();
   endtask

   task automatic test_mdu();
      mdu_pair("first");
      mdu_pair("second");
      drain();
   endtask

   task automatic test_redirect();
      set_id(5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1);         // j target
      #4;
      tests++; if (obs !== O_REDIR) begin fails++; $display("FAIL redir_plain got %b exp %b", obs, O_REDIR); end
      tick();
      set_idle();
      #4;
      tests++; if (obs !== O_RUN) begin fails++; $display("FAIL redir_one_cycle got %b exp %b", obs, O_RUN); end
      tick();
      set_id(5'd1, 1, 5'd1, 1, 0, 1, 5'd7, 0, 0, 0, 0);         // add $7
      #4; tick();
      set_id(5'd7, 1, 5'd0, 0, 1, 0, 5'd0, 0, 0, 0, 1);         // taken bgtz $7
      #4;
      tests++; if (obs !== O_EARLY) begin fails++; $display("FAIL redir_stalled got %b exp %b", obs, O_EARLY); end
      tick();
      #4;
      tests++; if (obs !== O_REDIR) begin fails++; $display("FAIL redir_after_stall got %b exp %b", obs, O_REDIR); end
      tick();
      drain();
   endtask

   task automatic test_reset_mid_stall();
      set_id(5'd29, 1, 5'd0, 0, 0, 1, 5'd2, 1, 0, 0, 0);        // lw $2
      #4; tick();
      set_id(5'd2, 1, 5'd4, 1, 0, 1, 5'd3, 0, 0, 0, 0);         // add $3,$2,$4
      #4;
      tests++; if (obs !== O_LU) begin fails++; $display("FAIL rst_pre_stall got %b exp %b", obs, O_LU); end
      #1 rst_n = 0;
      #1;
      tests++; if (obs !== O_RUN) begin fails++; $display("FAIL rst_mid_stall got %b exp %b", obs, O_RUN); end
      tick();
      rst_n = 1;
      #4;
      tests++; if (obs !== O_RUN) begin fails++; $display("FAIL rst_old_load got %b exp %b", obs, O_RUN); end
      tick();
      drain();
   endtask

   initial begin
      set_idle();
      rst_n = 0;
      test_reset();
      test_load_use();
      test_early();
      test_zero_reg();
      test_mdu();
      test_redirect();
      test_reset_mid_stall();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl_sb.md
# hazard_ctrl_sb

Parametrised pipeline hazard controller with a write scoreboard. It sits beside the IF/ID register of the pipelined CPU. It tracks in-flight register writers through EX/MEM/WB and decides load-use, branch/jump-register operand and multiply/divide-unit (MDU) hazards. It drives PC write-enable, IF/ID stall/flush and ID/EX bubble insertion. Unlike the previous hazard logic, it carries its own pipeline state: a scoreboard shift register and an MDU busy counter. Stage depth, operand-ready stages and MDU latency are parameters.

## Interface
- `NREG`, 32: architectural register count; `AW = $clog2(NREG)`
- `SB_DEPTH`, 3: tracked stages after ID (1=EX, 2=MEM, 3=WB)
- `ALU_READY`, 1: stage at whose end an ALU result becomes forwardable
- `LOAD_READY`, 2: stage at whose end load data becomes forwardable
- `MDU_LAT`, 8: cycles the MDU stays busy after a mult/div issues (≥1)
- `clk  in  1  clock`
- `rst_n  in  1  asynchronous active-low reset`
- `id_valid  in  1  ID holds a real instruction`
- `id_rs, id_rt  in  AW  source register addresses in ID`
- `id_rs_used, id_rt_used  in  1  operand actually read`
- `id_early  in  1  operands consumed in ID (beq/bne/bltz/bgez/blez/bgtz/jr/jalr)`
- `id_wr_en  in  1  instruction writes a GPR`
- `id_wr_addr  in  AW  destination register`
- `id_is_load  in  1  destination is load data`
- `id_mdu_issue  in  1  mult/multu/div/divu`
- `id_hilo_rd  in  1  mfhi/mflo`
- `id_redirect  in  1  taken branch/jump resolved in ID`
- `pc_we  out  1  PC write enable`
- `ifid_stall  out  1  hold IF/ID`
- `ifid_flush  out  1  clear IF/ID`
- `idex_flush  out  1  insert bubble into ID/EX`
- `mdu_busy  out  1  MDU counter non-zero`
- `stall_cause  out  2  0 none, 1 load-use, 2 early-operand, 3 MDU`

## Operation
- Scoreboard: `SB_DEPTH` entries, each with `{valid, addr, ready}` where `ready = id_is_load ? LOAD_READY : ALU_READY`. Entry s is the instruction currently in stage s.
- An operand matches entry s when it is used, is nonzero, the entry is valid, and the addresses are equal. Register 0 never hazards.
- Normal consumer (`id_early=0`): stalls on any match with `ready > s`.
- Early consumer: stalls on any match with `ready >= s`. With defaults: ALU producer in EX; load in EX or MEM.
- MDU: `id_mdu_issue` or `id_hilo_rd` stalls while `mdu_busy`.
- Priority for `stall_cause`: load-use > early-operand > MDU.
- `id_valid=0` never stalls.
- While a stall is active: `pc_we=0`, `ifid_stall=1`, `idex_flush=1`, `ifid_flush=0`.
- `id_redirect` with no stall: `ifid_flush=1`, `pc_we=1`.
- `id_redirect` during a stall is ignored. The redirect logic must re-assert it once the stall clears.
- Each clock, the scoreboard shifts s→s+1 and the last entry retires.
- Entry 1 load rules:
  - ID instruction with `id_valid && !stall && id_wr_en && id_wr_addr!=0`: entry 1 loads it.
  - During a stall: entry 1 loads invalid, matching the bubble.
  - Otherwise: entry 1 loads invalid.
- MDU counter: loads `MDU_LAT` on an unstalled `id_mdu_issue`; otherwise decrements toward 0 and saturates there.

## Timing
- Stall, flush and `pc_we` outputs are combinational from the ID inputs and registered state, with no added latency.
- Scoreboard and counter update on the `clk` rising edge.
- Reset (asynchronous, `rst_n` low):
  - All entries invalid; counter 0.
  - While in reset: `pc_we=1`, `ifid_stall=0`, `ifid_flush=0`, `idex_flush=0`, `mdu_busy=0`, `stall_cause=0`, regardless of inputs.
- Reset mid-stall releases the stall immediately.
- A load followed by a dependent ALU op gives exactly 1 stall cycle.
- A load followed by a dependent beq gives exactly 2 stall cycles.
- `mdu_busy` is high for `MDU_LAT` cycles after issue. `mfhi` issues in the cycle the counter reads 0.

## Configuration
- `HAZARD_STATS_EN`:
  - Defined: adds the outputs `stat_loaduse`, `stat_early` and `stat_mdu` (32-bit each). Each counts stall cycles for its cause, saturates at all-ones, and is cleared by reset.
  - Undefined: the ports and counters are absent. Stall behaviour is identical either way.

## Structure
- `hazard_pkg`: the `stall_cause_e` enum, the `sb_entry_t` struct `{valid, addr, ready}`, and the cause encodings.
- Sub-module `hazard_scoreboard`: the shift register plus per-stage compare. It returns match/ready-hit vectors for rs and rt.
- The top level holds the priority logic, the MDU counter and the optional statistics.

## Test plan
- `lw $2` then `add $3,$2,$4`: 1 cycle with `pc_we=0`, `idex_flush=1`, cause=1; `add` issues the next cycle.
- `add $5` then `beq $5,$6`: 1 stall cycle, cause=2. `lw $5` then `beq $5`: 2 stall cycles.
- Writer to `$0`, then a consumer of `$0`: no stall.
- `div` then `mflo` with `MDU_LAT=8`: 8 stall cycles, cause=3, then issue. A second `div` behaves the same.
- `id_redirect` with no hazard: `ifid_flush=1` for 1 cycle. `id_redirect` with an early-operand stall: `ifid_flush=0`.
- `rst_n` dropped mid load-use stall: outputs take reset values immediately. After release, the old load does not cause a stall.
